hs_inband_wr: RTL

- Ring-producer stage directly downstream of the SATA host command interface.
- Takes complete 4-word inband command entries from the command interface and writes them word-by-word into the inband ring BRAM.
- Maintains the producer index exported to the MicroBlaze (mb_io) and stalls when the consumer has not freed a slot.
- One entry is committed per request/acknowledge handshake.

---
 rtl/hs_inband_wr.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/hs_inband_wr.sv
// hs_inband_wr: inband ring producer stage.
//
// Takes complete 4-word command entries from the SATA host command interface and writes them
// into the inband ring BRAM, one 32-bit word per cycle. It then publishes the new producer
// index to the MicroBlaze. One entry is committed or aborted per ent_req/ent_ack handshake.
// One ring slot is always kept empty, so full means (prod+1) mod N == cons.
//
// Parameters:
//   C_RING_LOG2  log2 of ring entries (N = 2**C_RING_LOG2, max 11)
//   C_IDX_W      width of the producer/consumer index ports
//
// Ports:
//   sys_clk            clock
//   sys_rst            synchronous active-high reset (dominates PhyReset)
//   PhyReset           synchronous abort/flush from the link layer
//   ent_req            entry valid, held until ent_ack
//   ent_ack            one-cycle pulse: entry consumed
//   ent_err            with ent_ack: 1 = entry aborted, not committed
//   ent_id             command slot tag, placed in word 0 bits [31:27]
//   ent_data           entry payload, word k = ent_data[32k+31:32k]
//   ring_we            BRAM write enable
//   ring_addr          BRAM word address {prod_index, word_cnt}
//   ring_wdata         BRAM write data
//   inband_prod_index  producer index, zero-extended
//   inband_cons_index  consumer index, only the low C_RING_LOG2 bits are used
//   ring_full          combinational full flag
//   inband_irq         doorbell pulse (see HS_INBAND_IRQ_EN)
//
// Build option:
//   HS_INBAND_IRQ_EN  when defined, inband_irq pulses one cycle after a commit made into an
//                     empty ring (doorbell coalescing). When undefined, inband_irq is tied low.

module hs_inband_wr #(
  parameter int unsigned C_RING_LOG2 = 8,
  parameter int unsigned C_IDX_W     = 12
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   PhyReset,
  input  logic                   ent_req,
  output logic                   ent_ack,
  output logic                   ent_err,
  input  logic [4:0]             ent_id,
  input  logic [127:0]           ent_data,
  output logic                   ring_we,
  output logic [C_RING_LOG2+1:0] ring_addr,
  output logic [31:0]            ring_wdata,
  output logic [C_IDX_W-1:0]     inband_prod_index,
  input  logic [C_IDX_W-1:0]     inband_cons_index,
  output logic                   ring_full,
  output logic                   inband_irq
);

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StWrite,
    StCommit
  } state_e;

  state_e                 state_q, state_d;
  logic [C_RING_LOG2-1:0] prod_q, prod_d;
  logic [C_RING_LOG2-1:0] prod_inc;
  logic [C_RING_LOG2-1:0] cons_lo;
  logic [1:0]             word_cnt_q, word_cnt_d;
  logic                   abort_q, abort_d;
  logic [3:0][31:0]       words_q;
  logic                   latch_en;
  logic                   commit_ok;

  // Upper consumer-index bits and the overwritten tag field of word 0 are not needed.
  logic unused_inputs;
  assign unused_inputs = ^{inband_cons_index[C_IDX_W-1:C_RING_LOG2], ent_data[31:27]};

  assign cons_lo           = inband_cons_index[C_RING_LOG2-1:0];
  assign prod_inc          = prod_q + {{(C_RING_LOG2-1){1'b0}}, 1'b1};
  assign ring_full         = (prod_inc == cons_lo);
  assign inband_prod_index = C_IDX_W'(prod_q);
  assign ring_addr         = {prod_q, word_cnt_q};
  assign ring_wdata        = ring_we ? words_q[word_cnt_q] : 32'h0;

  always_comb begin
    state_d    = state_q;
    prod_d     = prod_q;
    word_cnt_d = word_cnt_q;
    abort_d    = abort_q;
    latch_en   = 1'b0;
    commit_ok  = 1'b0;
    ent_ack    = 1'b0;
    ent_err    = 1'b0;
    ring_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Full is only evaluated here; cons moving later cannot affect an entry in flight.
        if (ent_req && !ring_full && !PhyReset) begin
          latch_en = 1'b1;
          state_d  = StLatch;
        end
      end

      StLatch: begin
        word_cnt_d = 2'd0;
        abort_d    = PhyReset;
        state_d    = PhyReset ? StCommit : StWrite;
      end

      StWrite: begin
        if (PhyReset) begin
          // Words already written sit beyond prod and are invisible to the consumer.
          abort_d = 1'b1;
          state_d = StCommit;
        end else begin
          ring_we    = 1'b1;
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd3) begin
            // Index advances on the edge after the last write, so it is visible in the same
            // cycle as ent_ack and never ahead of the BRAM contents.
            prod_d    = prod_inc;
            commit_ok = 1'b1;
            state_d   = StCommit;
          end
        end
      end

      StCommit: begin
        ent_ack = 1'b1;
        ent_err = abort_q;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      prod_q     <= '0;
      word_cnt_q <= 2'd0;
      abort_q    <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      prod_q     <= prod_d;
      word_cnt_q <= word_cnt_d;
      abort_q    <= abort_d;
      if (latch_en) begin
        words_q <= {ent_data[127:32], ent_id, ent_data[26:0]};
      end
    end
  end

`ifdef HS_INBAND_IRQ_EN
  logic was_empty_q;
  logic irq_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      was_empty_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      // Emptiness is judged just before the index advances.
      if (commit_ok) begin
        was_empty_q <= (prod_q == cons_lo);
      end
      irq_q <= ent_ack && !ent_err && was_empty_q;
    end
  end

  assign inband_irq = irq_q;
`else
  logic unused_commit;
  assign unused_commit = commit_ok;
  assign inband_irq    = 1'b0;
`endif

endmodule
